// File: rtl/router_pkt_ctrl.sv
// Input-port packet controller: parses the header, steers header/payload/parity bytes
// to the addressed output FIFO, checks running parity and discards invalid-address packets.
module router_pkt_ctrl #(
    parameter  int DATA_W = 8,
    parameter  int ADDR_W = 2,
    localparam int NPORT  = 2**ADDR_W - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [NPORT-1:0]  fifo_full,
    output logic              busy,
    output logic [NPORT-1:0]  fifo_we,
    output logic [DATA_W-1:0] fifo_din,
    output logic              pkt_done,
    output logic              parity_err,
    output logic              pkt_drop
);

    localparam int CNT_W = DATA_W - ADDR_W;
    localparam int NSLOT = 2**ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAYLOAD,
        S_PARITY,
        S_CHECK,
        S_DROP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   dest_q, dest_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   parity_q, parity_d;
    logic                mismatch_q, mismatch_d;
    logic [NPORT-1:0]    fifo_we_q, fifo_we_d;
    logic [DATA_W-1:0]   fifo_din_q, fifo_din_d;
    logic                pkt_done_q, pkt_done_d;
    logic                parity_err_q, parity_err_d;
    logic                pkt_drop_q, pkt_drop_d;

    logic [ADDR_W-1:0]   hdr_addr;
    logic [CNT_W-1:0]    hdr_len;
    logic                addr_ok;
    logic [NSLOT-1:0]    full_ext;
    logic                busy_c;
    logic                accept;

    function automatic logic [NPORT-1:0] port_sel(input logic [ADDR_W-1:0] a);
        port_sel = NPORT'(1) << a;
    endfunction

    assign hdr_addr = data_in[ADDR_W-1:0];
    assign hdr_len  = data_in[DATA_W-1:ADDR_W];
    assign addr_ok  = (hdr_addr != {ADDR_W{1'b1}});
    // Pad the full flags so the invalid all-ones address indexes a constant 0.
    assign full_ext = {1'b0, fifo_full};

    always_comb begin
        busy_c = 1'b0;
        case (state_q)
            S_IDLE:              busy_c = pkt_valid & addr_ok & full_ext[hdr_addr];
            S_PAYLOAD, S_PARITY: busy_c = full_ext[dest_q];
            S_CHECK:             busy_c = 1'b1;
            default:             busy_c = 1'b0;
        endcase
    end

    assign accept = pkt_valid & ~busy_c;

    always_comb begin
        state_d      = state_q;
        dest_d       = dest_q;
        cnt_d        = cnt_q;
        parity_d     = parity_q;
        mismatch_d   = mismatch_q;
        fifo_we_d    = '0;
        fifo_din_d   = fifo_din_q;
        pkt_done_d   = 1'b0;
        parity_err_d = 1'b0;
        pkt_drop_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = hdr_len;
                    if (addr_ok) begin
                        dest_d     = hdr_addr;
                        parity_d   = data_in;
                        mismatch_d = 1'b0;
                        fifo_we_d  = port_sel(hdr_addr);
                        fifo_din_d = data_in;
                        state_d    = (hdr_len != '0) ? S_PAYLOAD : S_PARITY;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    fifo_we_d  = port_sel(dest_q);
                    fifo_din_d = data_in;
                    parity_d   = parity_q ^ data_in;
                    cnt_d      = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (accept) begin
                    fifo_we_d  = port_sel(dest_q);
                    fifo_din_d = data_in;
                    mismatch_d = (data_in != parity_q);
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                pkt_done_d   = 1'b1;
                parity_err_d = mismatch_q;
                state_d      = S_IDLE;
            end
            S_DROP: begin
                // Remaining payload is counted down, then the parity byte ends the drop.
                if (accept) begin
                    if (cnt_q == '0) begin
                        pkt_drop_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            dest_q       <= '0;
            cnt_q        <= '0;
            parity_q     <= '0;
            mismatch_q   <= 1'b0;
            fifo_we_q    <= '0;
            fifo_din_q   <= '0;
            pkt_done_q   <= 1'b0;
            parity_err_q <= 1'b0;
            pkt_drop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dest_q       <= dest_d;
            cnt_q        <= cnt_d;
            parity_q     <= parity_d;
            mismatch_q   <= mismatch_d;
            fifo_we_q    <= fifo_we_d;
            fifo_din_q   <= fifo_din_d;
            pkt_done_q   <= pkt_done_d;
            parity_err_q <= parity_err_d;
            pkt_drop_q   <= pkt_drop_d;
        end
    end

    assign busy       = busy_c;
    assign fifo_we    = fifo_we_q;
    assign fifo_din   = fifo_din_q;
    assign pkt_done   = pkt_done_q;
    assign parity_err = parity_err_q;
    assign pkt_drop   = pkt_drop_q;

endmodule

// File: tb/tb_router_pkt_ctrl.sv
// Bench for router_pkt_ctrl: directed cycle vectors followed by randomized packets
// checked against a packet-level scoreboard.
module tb_router_pkt_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int NPORT  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              pkt_valid;
    logic [DATA_W-1:0] data_in;
    logic [NPORT-1:0]  fifo_full;
    logic              busy;
    logic [NPORT-1:0]  fifo_we;
    logic [DATA_W-1:0] fifo_din;
    logic              pkt_done;
    logic              parity_err;
    logic              pkt_drop;

    router_pkt_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .fifo_full  (fifo_full),
        .busy       (busy),
        .fifo_we    (fifo_we),
        .fifo_din   (fifo_din),
        .pkt_done   (pkt_done),
        .parity_err (parity_err),
        .pkt_drop   (pkt_drop)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // One row: inputs applied at the falling edge, then combinational busy and the
    // registered outputs (produced by the previous rising edge) are compared.
    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic [2:0] full;
        logic       busy;
        logic [2:0] we;
        logic [7:0] din;
        logic       chk_din;
        logic       done;
        logic       err;
        logic       drop;
        int         tag;
    } vec_t;

    vec_t vecs[$];
    int   cur_tag;

    function automatic void add(input logic r, input logic v, input logic [7:0] d,
                                input logic [2:0] full, input logic b, input logic [2:0] we,
                                input logic [7:0] din, input logic cd, input logic done,
                                input logic err, input logic drop);
        vec_t t;
        t.r = r; t.v = v; t.d = d; t.full = full;
        t.busy = b; t.we = we; t.din = din; t.chk_din = cd;
        t.done = done; t.err = err; t.drop = drop; t.tag = cur_tag;
        vecs.push_back(t);
    endfunction

    // Header 0x0D: dest 1, len 3, payload 11 22 33; correct parity is 0x0D.
    function automatic void add_nominal(input logic [7:0] par, input logic exp_err);
        add(0, 1, 8'h0D, 3'b000, 0, 3'b000, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h11, 3'b000, 0, 3'b010, 8'h0D, 1, 0, 0, 0);
        add(0, 1, 8'h22, 3'b000, 0, 3'b010, 8'h11, 1, 0, 0, 0);
        add(0, 1, 8'h33, 3'b000, 0, 3'b010, 8'h22, 1, 0, 0, 0);
        add(0, 1, par,   3'b000, 0, 3'b010, 8'h33, 1, 0, 0, 0);
        add(0, 0, 8'h00, 3'b000, 1, 3'b010, par,   1, 0, 0, 0);
        add(0, 0, 8'h00, 3'b000, 0, 3'b000, 8'h00, 0, 1, exp_err, 0);
    endfunction

    typedef struct packed { logic [1:0] port; logic [7:0] b; } wr_t;
    typedef struct packed { logic drop; logic err; } ev_t;

    wr_t        exp_wr[$];
    ev_t        exp_ev[$];
    logic [7:0] tx[$];

    int         r_addr, r_len, r_flip;
    logic [7:0] r_hdr, r_byte, r_par, r_pb;
    wr_t        w;
    ev_t        e;
    logic       holding;
    logic [2:0] acc_full;
    logic       ok;

    initial begin
        rst       = 1'b1;
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        fifo_full = 3'b000;

        cur_tag = 0;
        add(1, 0, 8'h00, 3'b000, 0, 3'b000, 8'h00, 1, 0, 0, 0);
        add(1, 0, 8'h00, 3'b000, 0, 3'b000, 8'h00, 1, 0, 0, 0);
        add(0, 0, 8'h00, 3'b000, 0, 3'b000, 8'h00, 1, 0, 0, 0);

        cur_tag = 1;
        add_nominal(8'h0D, 1'b0);

        cur_tag = 2;
        add_nominal(8'h0C, 1'b1);

        cur_tag = 3;
        add(0, 1, 8'h0B, 3'b111, 0, 3'b000, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'hAA, 3'b111, 0, 3'b000, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'hBB, 3'b000, 0, 3'b000, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'hCC, 3'b000, 0, 3'b000, 8'h00, 0, 0, 0, 0);
        add(0, 0, 8'h00, 3'b000, 0, 3'b000, 8'h00, 0, 0, 0, 1);
        add(0, 0, 8'h00, 3'b000, 0, 3'b000, 8'h00, 0, 0, 0, 0);

        cur_tag = 4;
        add(0, 1, 8'h0D, 3'b010, 1, 3'b000, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h0D, 3'b000, 0, 3'b000, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h11, 3'b000, 0, 3'b010, 8'h0D, 1, 0, 0, 0);
        add(0, 1, 8'h22, 3'b010, 1, 3'b010, 8'h11, 1, 0, 0, 0);
        add(0, 1, 8'h22, 3'b010, 1, 3'b000, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h22, 3'b010, 1, 3'b000, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h22, 3'b010, 1, 3'b000, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h22, 3'b000, 0, 3'b000, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h33, 3'b001, 0, 3'b010, 8'h22, 1, 0, 0, 0);
        add(0, 1, 8'h0D, 3'b100, 0, 3'b010, 8'h33, 1, 0, 0, 0);
        add(0, 0, 8'h00, 3'b000, 1, 3'b010, 8'h0D, 1, 0, 0, 0);
        add(0, 0, 8'h00, 3'b000, 0, 3'b000, 8'h00, 0, 1, 0, 0);

        cur_tag = 5;
        add(0, 1, 8'h04, 3'b000, 0, 3'b000, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h55, 3'b000, 0, 3'b001, 8'h04, 1, 0, 0, 0);
        add(0, 1, 8'h51, 3'b000, 0, 3'b001, 8'h55, 1, 0, 0, 0);
        add(0, 1, 8'h00, 3'b000, 1, 3'b001, 8'h51, 1, 0, 0, 0);
        add(0, 1, 8'h00, 3'b000, 0, 3'b000, 8'h00, 0, 1, 0, 0);
        add(0, 1, 8'h00, 3'b000, 0, 3'b001, 8'h00, 1, 0, 0, 0);
        add(0, 0, 8'h00, 3'b000, 1, 3'b001, 8'h00, 1, 0, 0, 0);
        add(0, 0, 8'h00, 3'b000, 0, 3'b000, 8'h00, 0, 1, 0, 0);

        cur_tag = 6;
        add(0, 1, 8'h0D, 3'b000, 0, 3'b000, 8'h00, 0, 0, 0, 0);
        add(0, 1, 8'h11, 3'b000, 0, 3'b010, 8'h0D, 1, 0, 0, 0);
        add(0, 1, 8'h22, 3'b000, 0, 3'b010, 8'h11, 1, 0, 0, 0);
        add(1, 1, 8'h33, 3'b000, 0, 3'b000, 8'h00, 1, 0, 0, 0);
        add(1, 0, 8'h00, 3'b000, 0, 3'b000, 8'h00, 1, 0, 0, 0);
        add(0, 0, 8'h00, 3'b000, 0, 3'b000, 8'h00, 1, 0, 0, 0);
        add(0, 0, 8'h00, 3'b000, 0, 3'b000, 8'h00, 1, 0, 0, 0);
        add_nominal(8'h0D, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst       = vecs[i].r;
            pkt_valid = vecs[i].v;
            data_in   = vecs[i].d;
            fifo_full = vecs[i].full;
            #1;
            n_checks++;
            ok = (busy == vecs[i].busy) && (fifo_we == vecs[i].we) &&
                 (!vecs[i].chk_din || fifo_din == vecs[i].din) &&
                 (pkt_done == vecs[i].done) && (parity_err == vecs[i].err) &&
                 (pkt_drop == vecs[i].drop);
            if (!ok) begin
                n_fail++;
                $display("FAIL vec%0d scenario%0d: got busy=%b we=%b din=%h done=%b err=%b drop=%b, expected busy=%b we=%b din=%h done=%b err=%b drop=%b",
                         i, vecs[i].tag, busy, fifo_we, fifo_din, pkt_done, parity_err, pkt_drop,
                         vecs[i].busy, vecs[i].we, vecs[i].din, pkt_done ? vecs[i].done : vecs[i].done,
                         vecs[i].err, vecs[i].drop);
            end
        end

        // Random packets: the scoreboard is the ordered list of writes and completion events.
        for (int p = 0; p < 40; p++) begin
            r_addr = $urandom_range(0, 3);
            r_len  = (p == 7) ? 63 : $urandom_range(0, 5);
            r_hdr  = {r_len[5:0], r_addr[1:0]};
            r_par  = r_hdr;
            tx.push_back(r_hdr);
            if (r_addr != 3) begin
                w.port = r_addr[1:0]; w.b = r_hdr; exp_wr.push_back(w);
            end
            for (int k = 0; k < r_len; k++) begin
                r_byte = 8'($urandom_range(0, 255));
                tx.push_back(r_byte);
                r_par = r_par ^ r_byte;
                if (r_addr != 3) begin
                    w.port = r_addr[1:0]; w.b = r_byte; exp_wr.push_back(w);
                end
            end
            r_flip = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : 0;
            r_pb   = r_par ^ r_flip[7:0];
            tx.push_back(r_pb);
            if (r_addr != 3) begin
                w.port = r_addr[1:0]; w.b = r_pb; exp_wr.push_back(w);
                e.drop = 1'b0; e.err = (r_pb != r_par); exp_ev.push_back(e);
            end else begin
                e.drop = 1'b1; e.err = 1'b0; exp_ev.push_back(e);
            end
        end

        holding  = 1'b0;
        acc_full = 3'b000;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            if (fifo_we != 3'b000) begin
                n_checks++;
                if (exp_wr.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_write: got we=%b din=%h, expected no write", fifo_we, fifo_din);
                end else begin
                    w = exp_wr.pop_front();
                    if (fifo_we != (3'b001 << w.port) || fifo_din != w.b || (fifo_we & acc_full) != 3'b000) begin
                        n_fail++;
                        $display("FAIL rand_write: got we=%b din=%h (full at accept %b), expected we=%b din=%h",
                                 fifo_we, fifo_din, acc_full, 3'b001 << w.port, w.b);
                    end
                end
            end
            if (pkt_done || pkt_drop || parity_err) begin
                n_checks++;
                if (exp_ev.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_event: got done=%b err=%b drop=%b, expected no event",
                             pkt_done, parity_err, pkt_drop);
                end else begin
                    e = exp_ev.pop_front();
                    if (pkt_done != !e.drop || parity_err != e.err || pkt_drop != e.drop) begin
                        n_fail++;
                        $display("FAIL rand_event: got done=%b err=%b drop=%b, expected done=%b err=%b drop=%b",
                                 pkt_done, parity_err, pkt_drop, !e.drop, e.err, e.drop);
                    end
                end
            end
            if (tx.size() == 0 && exp_wr.size() == 0 && exp_ev.size() == 0) break;

            for (int j = 0; j < NPORT; j++) fifo_full[j] = ($urandom_range(0, 4) == 0);
            if (tx.size() > 0) begin
                pkt_valid = holding ? 1'b1 : ($urandom_range(0, 3) != 0);
                data_in   = tx[0];
            end else begin
                pkt_valid = 1'b0;
            end
            #1;
            acc_full = fifo_full;
            if (pkt_valid && !busy) begin
                void'(tx.pop_front());
                holding = 1'b0;
            end else begin
                holding = pkt_valid;
            end
        end

        n_checks++;
        if (tx.size() != 0 || exp_wr.size() != 0 || exp_ev.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain: got %0d bytes unsent, %0d writes and %0d events outstanding, expected 0",
                     tx.size(), exp_wr.size(), exp_ev.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
